// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode pipeline stage built around a DEPTH-entry FIFO.
// Fetch responses are queued while decode stalls and popped in program order
// when it advances. If the FIFO is empty, a response bypasses straight into the
// ID registers. A flush kills the queue and then discards the next FLUSH_DROP
// responses, which are the fetches that were already in flight.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_valid_i/pc_i/inst_i   fetch response
//   if_ready_o               FIFO has room (derived from registered count only)
//   stall_i                  decode cannot accept this cycle
//   flush_i                  taken jump/branch, kills queued + in-flight work
//   id_valid_o/pc_o/inst_o   registered instruction to decode
//   flush_done_o             no post-flush drops pending
//   count_o                  FIFO occupancy
//   overflow_o               sticky: response seen while not ready
module if_id_queue #(
  parameter int unsigned         XLEN        = 32,
  parameter int unsigned         DEPTH       = 2,
  parameter int unsigned         FLUSH_DROP  = 1,
  parameter logic [XLEN-1:0]     BUBBLE_INST = '0,
  localparam int unsigned        CW          = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic [XLEN-1:0] if_inst_i,
  output logic            if_ready_o,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_inst_o,
  output logic            flush_done_o,
  output logic [CW-1:0]   count_o,
  output logic            overflow_o
);

  localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  DROP_INIT = 3'(FLUSH_DROP);

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [2:0]      drop_cnt, drop_nxt;
  logic [CW-1:0]   count_nxt;
  logic            empty, accept, push, pop, bypass, dropping;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign if_ready_o = (count_o < CW'(DEPTH));
  assign empty      = (count_o == '0);

  // Flush and pending drops both veto acceptance; the drop counter only
  // decrements on real responses so in-flight fetches are matched one-for-one.
  assign accept   = if_valid_i && if_ready_o && !flush_i && (drop_cnt == '0);
  assign dropping = if_valid_i && !flush_i && (drop_cnt != '0);
  assign pop      = !flush_i && !stall_i && !empty;
  assign bypass   = !flush_i && !stall_i && empty && accept;
  // Bypass only when empty keeps program order: anything queued goes first.
  assign push     = accept && (stall_i || !empty);

  always_comb begin
    drop_nxt = drop_cnt;
    if (flush_i)       drop_nxt = DROP_INIT;
    else if (dropping) drop_nxt = drop_cnt - 3'd1;
  end

  always_comb begin
    count_nxt = count_o;
    if (flush_i) count_nxt = '0;
    else         count_nxt = count_o + CW'(push) - CW'(pop);
  end

  // Storage needs no reset: occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= if_pc_i;
      mem_inst[wr_ptr] <= if_inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_o      <= '0;
      drop_cnt     <= '0;
      flush_done_o <= 1'b1;
      overflow_o   <= 1'b0;
      id_valid_o   <= 1'b0;
      id_pc_o      <= '0;
      id_inst_o    <= BUBBLE_INST;
    end else begin
      if (flush_i)   wr_ptr <= '0;
      else if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (flush_i)   rd_ptr <= '0;
      else if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      count_o      <= count_nxt;
      drop_cnt     <= drop_nxt;
      flush_done_o <= (drop_nxt == '0);
      if (if_valid_i && !if_ready_o) overflow_o <= 1'b1;

      if (pop) begin
        id_valid_o <= 1'b1;
        id_pc_o    <= mem_pc[rd_ptr];
        id_inst_o  <= mem_inst[rd_ptr];
      end else if (bypass) begin
        id_valid_o <= 1'b1;
        id_pc_o    <= if_pc_i;
        id_inst_o  <= if_inst_i;
      end else begin
        id_valid_o <= 1'b0;
        id_pc_o    <= '0;
        id_inst_o  <= BUBBLE_INST;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned FDROP = 1;
  localparam logic [31:0] BUB   = 32'h0;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic            clk = 0, rst = 0;
  logic            if_valid_i = 0, stall_i = 0, flush_i = 0;
  logic [XLEN-1:0] if_pc_i = '0, if_inst_i = '0;
  logic            if_ready_o, id_valid_o, flush_done_o, overflow_o;
  logic [XLEN-1:0] id_pc_o, id_inst_o;
  logic [CW-1:0]   count_o;

  if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .FLUSH_DROP(FDROP), .BUBBLE_INST(BUB)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .if_ready_o(if_ready_o), .stall_i(stall_i), .flush_i(flush_i), .id_valid_o(id_valid_o),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .flush_done_o(flush_done_o),
    .count_o(count_o), .overflow_o(overflow_o));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  int          m_drop;
  bit          m_ovf, m_vld;
  logic [31:0] m_pc, m_inst;
  int          checks = 0, errors = 0;

  // Reference model: an in-order queue plus a drop counter, updated with the
  // inputs presented in the cycle, then the clock edge is taken.
  task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                     input bit st, input bit fl);
    bit   ready, acc;
    ent_t e;
    if_valid_i = v; if_pc_i = pc; if_inst_i = inst; stall_i = st; flush_i = fl;
    ready = (q.size() < DEPTH);
    if (v && !ready) m_ovf = 1;
    m_vld = 0; m_pc = '0; m_inst = BUB;
    if (fl) begin
      q.delete();
      m_drop = FDROP;
    end else begin
      acc = v && ready && (m_drop == 0);
      if (v && m_drop > 0) m_drop--;
      e.pc = pc; e.inst = inst;
      if (st) begin
        if (acc) q.push_back(e);
      end else if (q.size() > 0) begin
        ent_t h;
        h = q.pop_front();
        m_vld = 1; m_pc = h.pc; m_inst = h.inst;
        if (acc) q.push_back(e);
      end else if (acc) begin
        m_vld = 1; m_pc = pc; m_inst = inst;
      end
    end
    @(posedge clk); #1;
    if_valid_i = 0; stall_i = 0; flush_i = 0;
  endtask

  task automatic do_reset();
    rst = 1; if_valid_i = 0; stall_i = 0; flush_i = 0;
    @(posedge clk); #1;
    rst = 0;
    q.delete(); m_drop = 0; m_ovf = 0; m_vld = 0; m_pc = '0; m_inst = BUB;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (id_valid_o !== 1'b0)   begin errors++; $display("FAIL rst_valid got %0b exp 0", id_valid_o); end
    checks++; if (id_pc_o !== 32'h0)     begin errors++; $display("FAIL rst_pc got %h exp 0", id_pc_o); end
    checks++; if (id_inst_o !== BUB)     begin errors++; $display("FAIL rst_inst got %h exp %h", id_inst_o, BUB); end
    checks++; if (count_o !== '0)        begin errors++; $display("FAIL rst_count got %0d exp 0", count_o); end
    checks++; if (flush_done_o !== 1'b1) begin errors++; $display("FAIL rst_fdone got %0b exp 1", flush_done_o); end
    checks++; if (overflow_o !== 1'b0)   begin errors++; $display("FAIL rst_ovf got %0b exp 0", overflow_o); end
    checks++; if (if_ready_o !== 1'b1)   begin errors++; $display("FAIL rst_ready got %0b exp 1", if_ready_o); end
  endtask

  task automatic test_bypass();
    cyc(1, 32'h100, 32'h00A00093, 0, 0);
    checks++; if (id_valid_o !== 1'b1)      begin errors++; $display("FAIL byp_valid got %0b exp 1", id_valid_o); end
    checks++; if (id_pc_o !== 32'h100)      begin errors++; $display("FAIL byp_pc got %h exp 100", id_pc_o); end
    checks++; if (id_inst_o !== 32'h00A00093) begin errors++; $display("FAIL byp_inst got %h exp 00a00093", id_inst_o); end
    checks++; if (count_o !== '0)           begin errors++; $display("FAIL byp_count got %0d exp 0", count_o); end
  endtask

  task automatic test_stall();
    cyc(1, 32'h104, 32'h11, 1, 0);
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL stl_valid got %0b exp 0", id_valid_o); end
    cyc(1, 32'h108, 32'h22, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    checks++; if (count_o !== 2'd2)    begin errors++; $display("FAIL stl_count got %0d exp 2", count_o); end
    checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL stl_ready got %0b exp 0", if_ready_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL stl_valid2 got %0b exp 0", id_valid_o); end
    cyc(0, 32'h0, 32'h0, 0, 0);
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h104 || id_inst_o !== 32'h11)
      begin errors++; $display("FAIL stl_pop1 got %0b/%h/%h exp 1/104/11", id_valid_o, id_pc_o, id_inst_o); end
    cyc(0, 32'h0, 32'h0, 0, 0);
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h108 || id_inst_o !== 32'h22)
      begin errors++; $display("FAIL stl_pop2 got %0b/%h/%h exp 1/108/22", id_valid_o, id_pc_o, id_inst_o); end
    checks++; if (count_o !== '0) begin errors++; $display("FAIL stl_drain got %0d exp 0", count_o); end
  endtask

  task automatic test_overflow();
    cyc(1, 32'h110, 32'h33, 1, 0);
    cyc(1, 32'h114, 32'h44, 1, 0);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_pre got %0b exp 0", overflow_o); end
    cyc(1, 32'h10C, 32'h55, 1, 0);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow_o); end
    checks++; if (count_o !== 2'd2)    begin errors++; $display("FAIL ovf_count got %0d exp 2", count_o); end
    cyc(0, 32'h0, 32'h0, 0, 0);
    checks++; if (id_pc_o !== 32'h110) begin errors++; $display("FAIL ovf_pop1 got %h exp 110", id_pc_o); end
    cyc(0, 32'h0, 32'h0, 0, 0);
    checks++; if (id_pc_o !== 32'h114) begin errors++; $display("FAIL ovf_pop2 got %h exp 114", id_pc_o); end
    cyc(0, 32'h0, 32'h0, 0, 0);
    checks++; if (id_valid_o !== 1'b0 || overflow_o !== 1'b1)
      begin errors++; $display("FAIL ovf_after got v=%0b ovf=%0b exp v=0 ovf=1", id_valid_o, overflow_o); end
  endtask

  task automatic test_flush();
    cyc(1, 32'h120, 32'h66, 1, 0);
    cyc(1, 32'h124, 32'h77, 1, 0);
    cyc(1, 32'h200, 32'h88, 0, 1);
    checks++; if (count_o !== '0 || id_valid_o !== 1'b0 || flush_done_o !== 1'b0)
      begin errors++; $display("FAIL fl_state got c=%0d v=%0b fd=%0b exp 0/0/0", count_o, id_valid_o, flush_done_o); end
    cyc(1, 32'h204, 32'h99, 0, 0);
    checks++; if (flush_done_o !== 1'b1 || id_valid_o !== 1'b0)
      begin errors++; $display("FAIL fl_drop got fd=%0b v=%0b exp 1/0", flush_done_o, id_valid_o); end
    cyc(1, 32'h300, 32'hAA, 0, 0);
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h300)
      begin errors++; $display("FAIL fl_resume got %0b/%h exp 1/300", id_valid_o, id_pc_o); end
  endtask

  task automatic test_stall_flush();
    cyc(1, 32'h130, 32'hBB, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 1);
    checks++; if (count_o !== '0 || flush_done_o !== 1'b0 || id_valid_o !== 1'b0)
      begin errors++; $display("FAIL sf_state got c=%0d fd=%0b v=%0b exp 0/0/0", count_o, flush_done_o, id_valid_o); end
    cyc(1, 32'h400, 32'hCC, 0, 0);
    checks++; if (id_valid_o !== 1'b0 || flush_done_o !== 1'b1)
      begin errors++; $display("FAIL sf_drop got v=%0b fd=%0b exp 0/1", id_valid_o, flush_done_o); end
    cyc(1, 32'h404, 32'hDD, 0, 0);
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h404)
      begin errors++; $display("FAIL sf_resume got %0b/%h exp 1/404", id_valid_o, id_pc_o); end
  endtask

  task automatic test_reset_mid();
    cyc(1, 32'h500, 32'h1, 1, 0);
    cyc(1, 32'h504, 32'h2, 1, 0);
    do_reset();
    checks++; if (count_o !== '0 || id_valid_o !== 1'b0 || flush_done_o !== 1'b1 || overflow_o !== 1'b0 || if_ready_o !== 1'b1)
      begin errors++; $display("FAIL rm_state got c=%0d v=%0b fd=%0b ovf=%0b rdy=%0b exp 0/0/1/0/1",
                               count_o, id_valid_o, flush_done_o, overflow_o, if_ready_o); end
    cyc(0, 32'h0, 32'h0, 0, 1);
    do_reset();
    checks++; if (flush_done_o !== 1'b1) begin errors++; $display("FAIL rm_fdone got %0b exp 1", flush_done_o); end
    cyc(1, 32'h600, 32'h3, 0, 0);
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h600 || id_inst_o !== 32'h3)
      begin errors++; $display("FAIL rm_bypass got %0b/%h/%h exp 1/600/3", id_valid_o, id_pc_o, id_inst_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc($urandom_range(0, 9) < 7, $urandom, $urandom,
               $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
      checks++;
      if (id_valid_o !== m_vld || id_pc_o !== m_pc || id_inst_o !== m_inst)
        begin errors++; $display("FAIL rnd_id[%0d] got %0b/%h/%h exp %0b/%h/%h", i,
                                 id_valid_o, id_pc_o, id_inst_o, m_vld, m_pc, m_inst); end
      checks++;
      if (count_o !== CW'(q.size()) || if_ready_o !== (q.size() < DEPTH))
        begin errors++; $display("FAIL rnd_cnt[%0d] got c=%0d r=%0b exp c=%0d", i, count_o, if_ready_o, q.size()); end
      checks++;
      if (flush_done_o !== (m_drop == 0) || overflow_o !== m_ovf)
        begin errors++; $display("FAIL rnd_flags[%0d] got fd=%0b ovf=%0b exp fd=%0b ovf=%0b", i,
                                 flush_done_o, overflow_o, m_drop == 0, m_ovf); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_bypass();
    test_stall();
    test_overflow();
    test_flush();
    test_stall_flush();
    test_reset_mid();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised fetch-to-decode pipeline stage; successor to the single-entry IF/ID latch.
- Replaces the one-slot stall capture with a DEPTH-entry FIFO.
- Uses explicit valid/ready instead of the "pc != 0" and busy conventions.
- Adds a configurable in-flight drop count after a jump flush and a sticky overflow flag.
- Sits between the fetch/memory interface and the decoder.

Parameters:
- XLEN, 32: width of pc and instruction.
- DEPTH, 2: FIFO entries, >= 1; not required to be a power of two.
- FLUSH_DROP, 1: number of fetch responses discarded after a flush (the in-flight fetch), 0..7.
- BUBBLE_INST, 32'h0: instruction value driven on id_inst when id_valid is 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- if_valid_i  in  1  fetch response valid this cycle (replaces !busy).
- if_pc_i  in  XLEN  fetched pc.
- if_inst_i  in  XLEN  fetched instruction.
- if_ready_o  out  1  combinational; 1 when count_o < DEPTH.
- stall_i  in  1  decode cannot accept this cycle.
- flush_i  in  1  taken jump/branch; kill queued and in-flight instructions.
- id_valid_o  out  1  registered; id_pc_o/id_inst_o hold a real instruction.
- id_pc_o  out  XLEN  registered pc to decode.
- id_inst_o  out  XLEN  registered instruction to decode.
- flush_done_o  out  1  registered; 1 when no post-flush drops are pending (replaces jump_com).
- count_o  out  $clog2(DEPTH+1)  FIFO occupancy.
- overflow_o  out  1  sticky; set when if_valid_i arrives while if_ready_o is 0.

Behaviour:
- Reset (rst=1 at edge) clears everything:
  - id_valid_o=0, id_pc_o=0, id_inst_o=BUBBLE_INST.
  - count_o=0, read and write pointers =0, drop counter=0.
  - flush_done_o=1, overflow_o=0.
  - Applies mid-operation; all queued data is lost.
- Accept: an incoming response is accepted when if_valid_i=1, if_ready_o=1, flush_i=0 and the drop counter is 0.
- Drop: if if_valid_i=1 and drop counter >0 (and flush_i=0), the response is discarded and the counter decrements. flush_done_o rises on the edge where the counter reaches 0.
- Overflow: if_valid_i=1 with if_ready_o=0 discards the response and sets overflow_o until reset.
- Flush (highest priority after rst):
  - Takes priority over stall.
  - FIFO emptied (count=0, pointers reset); any response in the same cycle is discarded and not counted.
  - Drop counter loaded with FLUSH_DROP; flush_done_o <= (FLUSH_DROP==0).
  - id outputs <= bubble next cycle.
  - A flush during pending drops reloads the counter.
- Stall (stall_i=1, flush_i=0):
  - id outputs <= bubble; FIFO holds.
  - An accepted response is pushed if not full.
- Advance (stall_i=0, flush_i=0), in priority order:
  - a) FIFO non-empty: pop head into id regs, id_valid_o<=1; an accepted response is pushed in the same cycle, so count is unchanged.
  - b) FIFO empty and response accepted: bypass directly into id regs (latency 1 edge), no push.
  - c) Otherwise: bubble.
- Ordering: strict program order; bypass only when empty.
- Pointers wrap from DEPTH-1 to 0.
- count_o never exceeds DEPTH.
- if_ready_o is derived from registered count only; no combinational path from stall_i/flush_i.

Test Plan:
- Reset, then if_valid_i=1 with pc 0x100, inst 0x00A00093, stall_i=0 -> next cycle id_valid_o=1, id_pc_o=0x100, id_inst_o=0x00A00093, count_o=0.
- stall_i=1 for 3 cycles while pcs 0x104 and 0x108 arrive (DEPTH=2):
  - count_o=2, if_ready_o=0, id_valid_o=0 during the stall.
  - After release, 0x104 then 0x108 appear on consecutive cycles.
- Queue full and stalled, then pc 0x10C presented -> overflow_o=1 sticky; 0x10C never reaches id.
- With 2 entries queued, flush_i=1 together with valid pc 0x200:
  - Next cycle count_o=0, id_valid_o=0, flush_done_o=0.
  - Next response 0x204 is dropped and flush_done_o=1.
  - Following response 0x300 emerges on id.
- stall_i=1 and flush_i=1 in the same cycle -> flush wins: queue empty, drop counter=FLUSH_DROP.
- rst asserted with count_o=2 and drops pending -> all outputs at reset values next cycle; first post-reset response bypasses with latency 1.
